// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, completer FSM states and address helper
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

  // Word index inside a 256-word window; the caller range-checks the offset.
  function automatic logic [7:0] word_index(input logic [APB_ADDR_W-1:0] offset);
    return 8'(offset >> 2);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// rtl/apb_mem_slave_if.sv - APB bus between the stimulus master and the memory completer
interface apb_mem_slave_if;
  import apb_pkg::*;

  logic [APB_ADDR_W-1:0] apb_addr_i;
  logic                  apb_sel_i;
  logic                  apb_enable_i;
  logic                  apb_write_i;
  logic [APB_STRB_W-1:0] apb_strb_i;
  logic [2:0]            apb_prot_i;
  logic [APB_DATA_W-1:0] apb_wdata_i;
  logic                  apb_ready_o;
  logic [APB_DATA_W-1:0] apb_rdata_o;
  logic                  apb_slverr_o;

  modport master (
    output apb_addr_i, apb_sel_i, apb_enable_i, apb_write_i,
           apb_strb_i, apb_prot_i, apb_wdata_i,
    input  apb_ready_o, apb_rdata_o, apb_slverr_o
  );

  modport slave (
    input  apb_addr_i, apb_sel_i, apb_enable_i, apb_write_i,
           apb_strb_i, apb_prot_i, apb_wdata_i,
    output apb_ready_o, apb_rdata_o, apb_slverr_o
  );

endinterface

// File: rtl/apb_mem_slave_regbank.sv
// rtl/apb_mem_slave_regbank.sv - byte-strobed word storage with read-only ID in word 0
module apb_mem_slave_regbank
  import apb_pkg::*;
#(
  parameter logic [APB_DATA_W-1:0] ID        = '0,
  parameter int                    NUM_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [7:0]            rd_idx,
  output logic [APB_DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [7:0]            wr_idx,
  input  logic [APB_STRB_W-1:0] wr_strb,
  input  logic [APB_DATA_W-1:0] wr_data
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [APB_DATA_W-1:0] mem [NUM_WORDS];
  logic                  rd_ok;
  logic                  wr_ok;

  assign rd_ok = int'(rd_idx) < NUM_WORDS;
  // Word 0 is never stored: the ID constant is muxed in on reads.
  assign wr_ok = wr_en && clk_en && (wr_idx != 8'd0) && (int'(wr_idx) < NUM_WORDS);

  always_comb begin
    rd_data = '0;
    if (rd_idx == 8'd0) begin
      rd_data = ID;
    end else if (rd_ok) begin
      rd_data = mem[rd_idx[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB memory completer with wait states, SLVERR decode and transfer counter
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter logic [APB_DATA_W-1:0] ID          = '0,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    NUM_WORDS   = 16,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic           apb_clk_i,
  input  logic           apb_resetn_i,
  input  logic           apb_clk_en_i,
  apb_mem_slave_if.slave apb,
  output logic [15:0]    access_cnt_o
);

  localparam logic [APB_ADDR_W-1:0] SPAN      = APB_ADDR_W'(4 * NUM_WORDS);
  localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_CYCLES);

  apb_state_e state;
  apb_state_e next_state;

  logic [3:0]            wait_cnt;
  logic                  lat_write;
  logic                  lat_err;
  logic [APB_STRB_W-1:0] lat_strb;
  logic [APB_DATA_W-1:0] lat_wdata;
  logic [7:0]            lat_idx;

  logic                  ready_q;
  logic                  slverr_q;
  logic [APB_DATA_W-1:0] rdata_q;
  logic [15:0]           cnt_q;

  logic                  setup;
  logic                  access;
  logic [APB_ADDR_W-1:0] offset;
  logic [7:0]            dec_idx;
  logic                  dec_err;
  logic [7:0]            cur_idx;
  logic                  cur_err;
  logic                  cur_write;
  logic [APB_DATA_W-1:0] mem_rdata;
  logic                  commit;
  logic                  unused_prot;

  assign setup  = apb.apb_sel_i && !apb.apb_enable_i;
  assign access = apb.apb_sel_i && apb.apb_enable_i;

  // Wrapping subtraction pushes addresses below BASE_ADDR far out of range.
  assign offset  = apb.apb_addr_i - BASE_ADDR;
  assign dec_idx = word_index(offset);
  assign dec_err = (apb.apb_addr_i[1:0] != 2'b00) || (offset >= SPAN)
                || (apb.apb_write_i && (dec_idx == 8'd0));

  // With no wait states RESP is entered on the setup edge, before the latches hold the request.
  assign cur_idx   = (state == IDLE) ? dec_idx : lat_idx;
  assign cur_err   = (state == IDLE) ? dec_err : lat_err;
  assign cur_write = (state == IDLE) ? apb.apb_write_i : lat_write;

  assign commit      = (state == RESP) && access;
  assign unused_prot = ^apb.apb_prot_i;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (setup) begin
          next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!apb.apb_sel_i) begin
          next_state = IDLE;
        end else if (wait_cnt == 4'd1) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (access) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      state <= IDLE;
    end else if (apb_clk_en_i) begin
      state <= next_state;
    end
  end

  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      wait_cnt  <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_strb  <= '0;
      lat_wdata <= '0;
      lat_idx   <= '0;
    end else if (apb_clk_en_i) begin
      if ((state == IDLE) && setup) begin
        wait_cnt  <= WAIT_LOAD;
        lat_write <= apb.apb_write_i;
        lat_err   <= dec_err;
        lat_strb  <= apb.apb_strb_i;
        lat_wdata <= apb.apb_wdata_i;
        lat_idx   <= dec_idx;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else if (apb_clk_en_i) begin
      if (next_state == RESP) begin
        if (state != RESP) begin
          ready_q  <= 1'b1;
          slverr_q <= cur_err;
          rdata_q  <= (cur_write || cur_err) ? '0 : mem_rdata;
        end
      end else begin
        ready_q  <= 1'b0;
        slverr_q <= 1'b0;
        rdata_q  <= '0;
      end
    end
  end

  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      cnt_q <= '0;
    end else if (apb_clk_en_i && commit) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  apb_mem_slave_regbank #(
    .ID        (ID),
    .NUM_WORDS (NUM_WORDS)
  ) u_regbank (
    .clk     (apb_clk_i),
    .rst_n   (apb_resetn_i),
    .clk_en  (apb_clk_en_i),
    .rd_idx  (cur_idx),
    .rd_data (mem_rdata),
    .wr_en   (commit && lat_write && !lat_err),
    .wr_idx  (lat_idx),
    .wr_strb (lat_strb),
    .wr_data (lat_wdata)
  );

  assign apb.apb_ready_o  = ready_q;
  assign apb.apb_slverr_o = slverr_q;
  assign apb.apb_rdata_o  = rdata_q;
  assign access_cnt_o     = cnt_q;

endmodule
